decoder_scan: RTL

DECODER_SCAN -- requirements
Module: decoder_scan

---
 rtl/decoder_scan_if.sv | 19 +
 rtl/decoder_scan.sv | 129 ++++++++++++
 2 files changed

// File: rtl/decoder_scan_if.sv
// Bus bundle for decoder_scan: enable/mode/select/scan controls in, decoded outputs back.
interface decoder_scan_if #(
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned DWELL_W = 8
);
    localparam int unsigned N = 1 << SEL_W;

    logic               g;
    logic               mode;
    logic [SEL_W-1:0]   sel;
    logic [DWELL_W-1:0] dwell;
    logic [SEL_W-1:0]   last;
    logic [N-1:0]       y;
    logic [SEL_W-1:0]   idx;
    logic               wrap;

    modport master (output g, mode, sel, dwell, last, input y, idx, wrap);
    modport slave  (input g, mode, sel, dwell, last, output y, idx, wrap);
endinterface

// File: rtl/decoder_scan.sv
// One-cold active-low decoder with direct select and timed auto-scan modes.
// Optional macro DECODER_SCAN_BLANK_EN inserts a one-cycle all-off blank on every scan advance.
module decoder_scan #(
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned DWELL_W = 8
) (
    input  logic           clk,
    input  logic           clr_n,
    decoder_scan_if.slave  bus
);
    localparam int unsigned N = 1 << SEL_W;

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] DIRECT     = 2'd1;
    localparam logic [1:0] SCAN_HOLD  = 2'd2;
`ifdef DECODER_SCAN_BLANK_EN
    localparam logic [1:0] SCAN_BLANK = 2'd3;
`endif

    logic [1:0]         state, state_nxt;
    logic [N-1:0]       y, y_nxt;
    logic [SEL_W-1:0]   idx, idx_nxt;
    logic               wrap, wrap_nxt;
    logic [DWELL_W-1:0] cnt, cnt_nxt;
    logic               frozen, frozen_nxt;
    logic               in_scan_c;
    logic               wrap_adv_c;
    logic [SEL_W-1:0]   idx_adv_c;

    function automatic logic [N-1:0] one_cold(input logic [SEL_W-1:0] s);
        return ~(N'(1) << s);
    endfunction

`ifdef DECODER_SCAN_BLANK_EN
    assign in_scan_c = (state == SCAN_HOLD) || (state == SCAN_BLANK);
`else
    assign in_scan_c = (state == SCAN_HOLD);
`endif

    // An index above LAST (LAST lowered mid-scan) also wraps on its next advance
    assign wrap_adv_c = (idx >= bus.last);
    assign idx_adv_c  = wrap_adv_c ? '0 : idx + SEL_W'(1);

    always_comb begin
        state_nxt  = state;
        y_nxt      = y;
        idx_nxt    = idx;
        wrap_nxt   = 1'b0;
        cnt_nxt    = cnt;
        frozen_nxt = frozen;
        if (bus.g) begin
            // Freeze scan progress so a later re-enable resumes where it stopped
            state_nxt = IDLE;
            y_nxt     = '1;
            if (in_scan_c) begin
                frozen_nxt = 1'b1;
            end else if (state == DIRECT) begin
                frozen_nxt = 1'b0;
            end
        end else if (!bus.mode) begin
            state_nxt  = DIRECT;
            y_nxt      = one_cold(bus.sel);
            idx_nxt    = bus.sel;
            cnt_nxt    = '0;
            frozen_nxt = 1'b0;
        end else begin
            frozen_nxt = 1'b0;
            state_nxt  = SCAN_HOLD;
            case (state)
                SCAN_HOLD: begin
                    if (cnt == bus.dwell) begin
                        cnt_nxt  = '0;
                        idx_nxt  = idx_adv_c;
                        wrap_nxt = wrap_adv_c;
`ifdef DECODER_SCAN_BLANK_EN
                        state_nxt = SCAN_BLANK;
                        y_nxt     = '1;
`else
                        y_nxt     = one_cold(idx_adv_c);
`endif
                    end else begin
                        cnt_nxt = cnt + DWELL_W'(1);
                    end
                end
`ifdef DECODER_SCAN_BLANK_EN
                SCAN_BLANK: begin
                    y_nxt = one_cold(idx);
                end
`endif
                IDLE: begin
                    if (frozen) begin
                        y_nxt = one_cold(idx);
                    end else begin
                        idx_nxt = '0;
                        cnt_nxt = '0;
                        y_nxt   = one_cold(SEL_W'(0));
                    end
                end
                default: begin
                    idx_nxt = '0;
                    cnt_nxt = '0;
                    y_nxt   = one_cold(SEL_W'(0));
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state  <= IDLE;
            y      <= '1;
            idx    <= '0;
            wrap   <= 1'b0;
            cnt    <= '0;
            frozen <= 1'b0;
        end else begin
            state  <= state_nxt;
            y      <= y_nxt;
            idx    <= idx_nxt;
            wrap   <= wrap_nxt;
            cnt    <= cnt_nxt;
            frozen <= frozen_nxt;
        end
    end

    assign bus.y    = y;
    assign bus.idx  = idx;
    assign bus.wrap = wrap;
endmodule
